// File: rtl/iter_unit_arbiter.sv
// rtl/iter_unit_arbiter.sv - round-robin arbiter sharing one iterative unit between two requesters
module iter_unit_arbiter #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] din0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] din1,
    output logic              gnt1,
    output logic [RES_W-1:0]  dout,
    output logic              dout_vld0,
    output logic              dout_vld1,
    output logic              err,
    output logic              unit_start,
    output logic [DATA_W-1:0] unit_din,
    input  logic              unit_ready,
    input  logic [RES_W-1:0]  unit_result,
    output logic              busy
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic            to_flag;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            timeout_hit;
    logic            winner;

    // On a tie the requester that did not own the previous job wins.
    assign winner      = (req0 && req1) ? ~last_owner : req1;
    assign wd_inc      = wd + 1'b1;
    assign timeout_hit = (wd_inc == WD_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            to_flag    <= 1'b0;
            wd         <= '0;
            unit_din   <= '0;
            dout       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((req0 || req1) && unit_ready) begin
                        unit_din   <= winner ? din1 : din0;
                        owner      <= winner;
                        last_owner <= winner;
                        state      <= START;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    wd <= wd_inc;
                    if (timeout_hit) begin
                        dout    <= '0;
                        to_flag <= 1'b1;
                        state   <= DONE;
                    end else if (!unit_ready) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    wd <= wd_inc;
                    // A completion on the same edge as the timeout is kept.
                    if (unit_ready) begin
                        dout  <= unit_result;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        dout    <= '0;
                        to_flag <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    to_flag <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        gnt0       = (state == START) && !owner;
        gnt1       = (state == START) && owner;
        unit_start = (state == START);
        dout_vld0  = (state == DONE) && !owner;
        dout_vld1  = (state == DONE) && owner;
        err        = (state == DONE) && to_flag;
        busy       = (state != IDLE);
    end
endmodule
